// File: rtl/xdmarb.sv
// xdmarb: two-source DMA request arbiter.
// Per-source FIFOs feed one output register with round-robin grant.
module xdmarb #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             xdmarb_clk,
  input  logic             xdmarb_rst,
  input  logic [42:0]      s0_xdfil2dma_req_data,
  input  logic             s0_xdfil2dma_req_valid,
  output logic             s0_xdfil2dma_req_stall,
  input  logic [42:0]      s1_xdfil2dma_req_data,
  input  logic             s1_xdfil2dma_req_valid,
  output logic             s1_xdfil2dma_req_stall,
  output logic [43:0]      xdmarb2dma_req_data,
  output logic             xdmarb2dma_req_valid,
  input  logic             xdmarb2dma_req_stall,
  output logic [CNT_W-1:0] xdmarb_s0_cnt,
  output logic [CNT_W-1:0] xdmarb_s1_cnt,
  output logic             xdmarb_idle
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL = OW'(FIFO_DEPTH);

  logic [42:0]      mem [2][FIFO_DEPTH];
  logic [AW-1:0]    wp [2];
  logic [AW-1:0]    rp [2];
  logic [OW-1:0]    occ [2];
  logic [CNT_W-1:0] cnt [2];
  logic [42:0]      in_data [2];
  logic [42:0]      head [2];
  logic [1:0]       in_valid;
  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic             load;
  logic             any;
  logic             gid;
  logic             last;

  always_comb begin
    in_data[0] = s0_xdfil2dma_req_data;
    in_data[1] = s1_xdfil2dma_req_data;
    in_valid   = {s1_xdfil2dma_req_valid,
                  s0_xdfil2dma_req_valid};
    for (int i = 0; i < 2; i++) begin
      full[i]  = (occ[i] == FULL);
      empty[i] = (occ[i] == '0);
      head[i]  = mem[i][rp[i]];
      push[i]  = in_valid[i] & ~full[i]
               & ~xdmarb_rst;
    end
    load = ~xdmarb2dma_req_valid
         | ~xdmarb2dma_req_stall;
    any  = ~&empty;
    // On a tie the source not granted last wins.
    gid  = (~empty[0] & ~empty[1]) ? ~last
                                   : empty[0];
    pop[0] = load & any & ~gid;
    pop[1] = load & any & gid;
  end

  assign s0_xdfil2dma_req_stall = full[0] | xdmarb_rst;
  assign s1_xdfil2dma_req_stall = full[1] | xdmarb_rst;
  assign xdmarb_s0_cnt = cnt[0];
  assign xdmarb_s1_cnt = cnt[1];
  assign xdmarb_idle   = empty[0] & empty[1]
                       & ~xdmarb2dma_req_valid;

  always_ff @(posedge xdmarb_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wp[i]] <= in_data[i];
    end
  end

  always_ff @(posedge xdmarb_clk) begin
    if (xdmarb_rst) begin
      for (int i = 0; i < 2; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        occ[i] <= '0;
        cnt[i] <= '0;
      end
      xdmarb2dma_req_valid <= 1'b0;
      xdmarb2dma_req_data  <= '0;
      last                 <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wp[i] <= wp[i] + AW'(1);
        if (pop[i])  rp[i] <= rp[i] + AW'(1);
        occ[i] <= occ[i] + OW'(push[i])
                - OW'(pop[i]);
        if (push[i] && cnt[i] != '1)
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
      if (load) begin
        xdmarb2dma_req_valid <= any;
        if (any) begin
          xdmarb2dma_req_data <= {gid, head[gid]};
          last                <= gid;
        end
      end
    end
  end

endmodule

// File: tb/tb_xdmarb.sv
// tb_xdmarb: queue-based reference model plus directed
// and random stimulus for xdmarb.
module tb_xdmarb;

  localparam int FD   = 2;
  localparam int CW   = 4;
  localparam int MAXC = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [42:0]   s0_data, s1_data;
  logic          s0_valid, s1_valid;
  logic          s0_stall, s1_stall;
  logic [43:0]   out_data;
  logic          out_valid;
  logic          dma_stall;
  logic [CW-1:0] cnt0, cnt1;
  logic          idle;

  xdmarb #(.FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .xdmarb_clk             (clk),
    .xdmarb_rst             (rst),
    .s0_xdfil2dma_req_data  (s0_data),
    .s0_xdfil2dma_req_valid (s0_valid),
    .s0_xdfil2dma_req_stall (s0_stall),
    .s1_xdfil2dma_req_data  (s1_data),
    .s1_xdfil2dma_req_valid (s1_valid),
    .s1_xdfil2dma_req_stall (s1_stall),
    .xdmarb2dma_req_data    (out_data),
    .xdmarb2dma_req_valid   (out_valid),
    .xdmarb2dma_req_stall   (dma_stall),
    .xdmarb_s0_cnt          (cnt0),
    .xdmarb_s1_cnt          (cnt1),
    .xdmarb_idle            (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit armed = 0;
  bit a0, a1;

  logic [42:0] q0[$];
  logic [42:0] q1[$];
  bit          mvalid = 0;
  logic [43:0] mdata = '0;
  bit          mlast = 1;
  int          mc0 = 0, mc1 = 0;

  bit          oid[$];
  int          ocyc[$];
  logic [43:0] odat[$];
  int          n0, n1;

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit midle();
    return q0.size() == 0 && q1.size() == 0 && !mvalid;
  endfunction

  function automatic logic [42:0] mk(int s, int k);
    return {3'(k), 8'(s), 32'(k * 4 + 'h100)};
  endfunction

  // Compare DUT with model, then advance model one cycle.
  task automatic cycle();
    bit g;
    #1;
    if (armed) begin
      check("s0_stall", s0_stall,
            (q0.size() == FD) || rst);
      check("s1_stall", s1_stall,
            (q1.size() == FD) || rst);
      check("out_valid", out_valid, mvalid);
      if (mvalid) check("out_data", out_data, mdata);
      check("s0_cnt", cnt0, mc0);
      check("s1_cnt", cnt1, mc1);
      check("idle", idle, midle());
    end
    if (out_valid === 1'b1 && !dma_stall && !rst) begin
      oid.push_back(out_data[43]);
      ocyc.push_back(cyc);
      odat.push_back(out_data);
    end
    a0 = !rst && s0_valid && q0.size() < FD;
    a1 = !rst && s1_valid && q1.size() < FD;
    if (rst) begin
      q0.delete();
      q1.delete();
      mvalid = 0;
      mdata = '0;
      mlast = 1;
      mc0 = 0;
      mc1 = 0;
      armed = 1;
    end else begin
      if (!mvalid || !dma_stall) begin
        if (q0.size() != 0 || q1.size() != 0) begin
          if (q0.size() != 0 && q1.size() != 0) g = !mlast;
          else g = (q0.size() == 0);
          if (g) mdata = {1'b1, q1.pop_front()};
          else   mdata = {1'b0, q0.pop_front()};
          mvalid = 1;
          mlast = g;
        end else begin
          mvalid = 0;
        end
      end
      if (a0) begin
        q0.push_back(s0_data);
        if (mc0 < MAXC) mc0++;
      end
      if (a1) begin
        q1.push_back(s1_data);
        if (mc1 < MAXC) mc1++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic stream(int t0, int t1, int budget);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      s0_valid = (n0 < t0);
      s0_data  = mk(0, n0);
      s1_valid = (n1 < t1);
      s1_data  = mk(1, n1);
      cycle();
      if (a0) n0++;
      if (a1) n1++;
      done = (n0 >= t0) && (n1 >= t1) && midle();
    end
    s0_valid = 0;
    s1_valid = 0;
    check("stream_done", done, 1);
  endtask

  initial begin
    int bad, j0, j1;
    bit have;
    logic [43:0] held;
    rst = 1;
    s0_valid = 0;
    s1_valid = 0;
    s0_data = '0;
    s1_data = '0;
    dma_stall = 0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 0;
    #1;
    check("post_rst_idle", idle, 1);
    check("post_rst_stalls", {s0_stall, s1_stall}, 0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_cnt", {cnt0, cnt1}, 0);

    // single request, two-cycle latency
    s0_valid = 1;
    s0_data = 43'h0123456780;
    cycle();
    s0_valid = 0;
    check("lat_n1_valid", out_valid, 0);
    cycle();
    check("lat_n2_valid", out_valid, 1);
    check("lat_n2_data", out_data, 44'h00123456780);
    check("single_cnt", cnt0, 1);
    cycle();
    check("single_idle", idle, 1);

    // contention after a fresh reset
    rst = 1;
    cycle();
    rst = 0;
    oid.delete(); ocyc.delete(); odat.delete();
    n0 = 0;
    n1 = 0;
    stream(8, 8, 60);
    check("cont_count", oid.size(), 16);
    bad = 0;
    j0 = 0;
    j1 = 0;
    foreach (oid[k]) begin
      if (oid[k] != bit'(k % 2)) bad++;
      if (oid[k] == 0) begin
        if (odat[k][42:0] !== mk(0, j0)) bad++;
        j0++;
      end else begin
        if (odat[k][42:0] !== mk(1, j1)) bad++;
        j1++;
      end
    end
    check("cont_alt_order", bad, 0);
    if (oid.size() == 16)
      check("cont_consecutive", ocyc[15] - ocyc[0], 15);

    // backpressure from the DMA side
    oid.delete(); ocyc.delete(); odat.delete();
    n1 = 0;
    dma_stall = 1;
    have = 0;
    bad = 0;
    held = '0;
    for (int c = 0; c < 10; c++) begin
      s1_valid = 1;
      s1_data = mk(1, n1);
      cycle();
      if (a1) n1++;
      if (out_valid) begin
        if (!have) begin
          held = out_data;
          have = 1;
        end else if (out_data !== held) bad++;
      end
    end
    check("bp_accepts", n1, FD + 1);
    check("bp_s1_stall", s1_stall, 1);
    check("bp_have", have, 1);
    check("bp_held", bad, 0);
    dma_stall = 0;
    s1_data = mk(1, n1);
    check("full_edge_c", s1_stall, 1);
    cycle();
    if (a1) n1++;
    check("full_edge_c1", s1_stall, 0);
    stream(0, 6, 60);
    check("bp_delivered", oid.size(), 6);

    // reset in the middle of a stalled burst
    n0 = 0;
    n1 = 0;
    dma_stall = 1;
    for (int c = 0; c < 6; c++) begin
      s0_valid = 1;
      s0_data = mk(0, n0);
      s1_valid = 1;
      s1_data = mk(1, n1);
      cycle();
      if (a0) n0++;
      if (a1) n1++;
    end
    check("pre_rst_full",
          {s0_stall, s1_stall, out_valid}, 3'b111);
    rst = 1;
    #1;
    check("rst_stalls", {s0_stall, s1_stall}, 2'b11);
    cycle();
    rst = 0;
    check("rst_valid", out_valid, 0);
    check("rst_cnt", {cnt0, cnt1}, 0);
    dma_stall = 0;
    s0_data = mk(0, 100);
    s1_data = mk(1, 100);
    cycle();
    s0_valid = 0;
    s1_valid = 0;
    cycle();
    check("tie_rst_valid", out_valid, 1);
    check("tie_rst_id", out_data[43], 0);
    cycle();
    cycle();

    // counter saturation
    n0 = 0;
    n1 = 0;
    stream(20, 0, 80);
    check("sat_15", cnt0, 15);
    repeat (3) cycle();
    check("sat_hold", cnt0, 15);

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      s0_valid = $urandom_range(0, 1) == 1;
      s1_valid = $urandom_range(0, 1) == 1;
      s0_data = 43'({$urandom(), $urandom()});
      s1_data = 43'({$urandom(), $urandom()});
      dma_stall = ($urandom_range(0, 2) == 0);
      cycle();
    end
    rst = 0;
    s0_valid = 0;
    s1_valid = 0;
    dma_stall = 0;
    repeat (6) cycle();
    check("final_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
